// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, GF(2^8) helpers, S-box, round constants.
// No configuration macros are used in this file.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} aes_fsm_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic int aes_nr(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as x^254 = prod over k=1..7 of x^(2^k); 0 maps to 0, then the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/KeyExpansion.sv
// Combinational AES key schedule; all Nr+1 round keys flattened, round 0 in the MSBs.
module KeyExpansion
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic [Nk*32-1:0]              key,
  output logic [128*(aes_nr(Nk)+1)-1:0] round_keys
);

  localparam int NR = aes_nr(Nk);
  localparam int NW = 4 * (NR + 1);

  for (genvar i = 0; i < NW; i++) begin : g_w
    logic [31:0] w;
    if (i < Nk) begin : g_key
      assign w = key[32*(Nk-i)-1 -: 32];
    end else if (i % Nk == 0) begin : g_rot
      assign w = g_w[i-Nk].w ^ {RCON[i/Nk-1], 24'h0} ^
                 sub_word({g_w[i-1].w[23:0], g_w[i-1].w[31:24]});
    end else if (Nk > 6 && i % Nk == 4) begin : g_sub
      assign w = g_w[i-Nk].w ^ sub_word(g_w[i-1].w);
    end else begin : g_xor
      assign w = g_w[i-Nk].w ^ g_w[i-1].w;
    end
    assign round_keys[128*(NR+1)-1-32*i -: 32] = w;
  end

endmodule

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the
// final round), AddRoundKey. Byte n of the state sits in bits [127-8n -: 8].
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [127:0] sr_flat;
  logic [127:0] mc;

  for (genvar n = 0; n < 16; n++) begin : g_sub
    assign sb[n] = sbox(state[127-8*n -: 8]);
  end

  // Row r of column c takes the byte from column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
      assign sr_flat[127-8*(4*c+r) -: 8] = sr[4*c+r];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];

    assign mc[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end

  assign next_state = (final_round ? sr_flat : mc) ^ round_key;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryptor, one round per clock, valid/ready on both sides.
// Optional macro AES_CIPHER_KEY_REUSE_EN adds key_reuse to keep the previous key.
//
// state | meaning
// IDLE  | waiting for a plaintext/key pair, in_ready=1
// LOAD  | initial AddRoundKey with rk[0]
// ROUND | one cipher round per cycle, rounds 1..Nr
// DONE  | ciphertext presented until out_ready
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       data_in,
  input  logic [Nk*32-1:0]   key,
`ifdef AES_CIPHER_KEY_REUSE_EN
  input  logic               key_reuse,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       data_out
);

  localparam int Nr = aes_nr(Nk);
  localparam logic [3:0] NR_Q = 4'(Nr);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_cipher_iter: Nk must be 4, 6 or 8");
  end

  aes_fsm_t                 fsm_q, fsm_d;
  logic [127:0]             pt_q;
  logic [127:0]             state_q;
  logic [Nk*32-1:0]         key_q;
  logic [3:0]               round_q;
  logic [128*(Nr+1)-1:0]    round_keys;
  logic [127:0]             rk [Nr+1];
  logic [127:0]             round_out;
  logic                     final_round;
  logic                     accept;

  KeyExpansion #(.Nk(Nk)) u_key_exp (
    .key        (key_q),
    .round_keys (round_keys)
  );

  for (genvar i = 0; i <= Nr; i++) begin : g_rk
    assign rk[i] = round_keys[128*(Nr+1)-1-128*i -: 128];
  end

  assign final_round = (round_q == NR_Q);

  aes_round u_round (
    .state       (state_q),
    .round_key   (rk[round_q]),
    .final_round (final_round),
    .next_state  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = LOAD;
      LOAD:    fsm_d = ROUND;
      ROUND:   if (final_round) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 during reset as well.
  always_comb begin
    in_ready  = rst_n && (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
  end

  assign accept   = in_valid && in_ready;
  assign data_out = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q    <= '0;
      key_q   <= '0;
      state_q <= '0;
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (accept) begin
          pt_q <= data_in;
`ifdef AES_CIPHER_KEY_REUSE_EN
          if (!key_reuse) key_q <= key;
`else
          key_q <= key;
`endif
        end
        LOAD: begin
          state_q <= pt_q ^ rk[0];
          round_q <= 4'd1;
        end
        ROUND: begin
          state_q <= round_out;
          if (round_q != NR_Q) round_q <= round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors for Nk=4/6/8, latency,
// backpressure, busy input, mid-operation reset and (when enabled) key reuse.
module tb_aes_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid [3];
  logic         in_ready [3];
  logic         out_valid [3];
  logic [127:0] dout [3];
  logic [127:0] data_in;
  logic [255:0] key_bus;
  logic         out_ready;
`ifdef AES_CIPHER_KEY_REUSE_EN
  logic         key_reuse;
`endif

  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] sb [$];

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  always #5 clk = ~clk;

  aes_cipher_iter #(.Nk(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in), .key(key_bus[255:128]),
`ifdef AES_CIPHER_KEY_REUSE_EN
    .key_reuse(key_reuse),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready), .data_out(dout[0]));

  aes_cipher_iter #(.Nk(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in), .key(key_bus[255:64]),
`ifdef AES_CIPHER_KEY_REUSE_EN
    .key_reuse(key_reuse),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready), .data_out(dout[1]));

  aes_cipher_iter #(.Nk(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in), .key(key_bus),
`ifdef AES_CIPHER_KEY_REUSE_EN
    .key_reuse(key_reuse),
`endif
    .out_valid(out_valid[2]), .out_ready(out_ready), .data_out(dout[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected ciphertext at accept, pop it when out_valid appears.
  task automatic run_block(input int w, input logic [127:0] pt, input logic [255:0] k,
                           input logic [127:0] exp, input int lat_exp,
                           input int hold, input bit poke);
    int n;
    logic [127:0] got;
    data_in = pt;
    key_bus = k;
    in_valid[w] = 1'b1;
    n = 0;
    while (!in_ready[w] && n < 20) begin
      step();
      n++;
    end
    chk("accept_ready", 128'(in_ready[w]), 128'd1);
    step();
    in_valid[w] = 1'b0;
    sb.push_back(exp);
    n = 0;
    while (!out_valid[w] && n < 40) begin
      if (poke && (n == 3 || n == 6)) begin
        in_valid[w] = 1'b1;
        data_in = ~pt;
        key_bus = ~k;
      end else begin
        in_valid[w] = 1'b0;
      end
      step();
      n++;
    end
    in_valid[w] = 1'b0;
    chk("latency", 128'(n), 128'(lat_exp));
    if (sb.size() == 0) got = 'x;
    else got = sb.pop_front();
    chk("data_out", dout[w], got);
    for (int i = 0; i < hold; i++) begin
      in_valid[w] = poke ? ~in_valid[w] : 1'b0;
      data_in = ~pt;
      step();
      chk("hold_data", dout[w], got);
      chk("hold_in_ready", 128'(in_ready[w]), 128'd0);
      chk("hold_out_valid", 128'(out_valid[w]), 128'd1);
    end
    in_valid[w] = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_out_valid", 128'(out_valid[w]), 128'd0);
    chk("post_in_ready", 128'(in_ready[w]), 128'd1);
    step();
    step();
    chk("still_idle", 128'(in_ready[w]), 128'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    data_in   = '0;
    key_bus   = '0;
    out_ready = 1'b0;
`ifdef AES_CIPHER_KEY_REUSE_EN
    key_reuse = 1'b0;
`endif

    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 128'(in_ready[i]), 128'd0);
      chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
      chk("rst_data_out", dout[i], 128'h0);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) chk("rel_in_ready", 128'(in_ready[i]), 128'd1);

    run_block(0, PT_B, KEY_B, CT_B, 11, 0, 1'b0);
    run_block(0, PT_C, KEY_C, CT_C1, 11, 0, 1'b0);
    run_block(1, PT_C, KEY_C, CT_C2, 13, 0, 1'b0);
    run_block(2, PT_C, KEY_C, CT_C3, 15, 0, 1'b0);
    run_block(0, PT_B, KEY_B, CT_B, 11, 20, 1'b1);

    // Reset during round 5 of a C.1 block on the Nk=4 core.
    data_in = PT_C;
    key_bus = KEY_C;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    repeat (5) step();
    chk("mid_busy", 128'(in_ready[0]), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_data_out", dout[0], 128'h0);
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    run_block(0, PT_C, KEY_C, CT_C1, 11, 0, 1'b0);

`ifdef AES_CIPHER_KEY_REUSE_EN
    key_reuse = 1'b0;
    run_block(0, PT_C, KEY_C, CT_C1, 11, 0, 1'b0);
    key_reuse = 1'b1;
    run_block(0, PT_C, {256{1'b1}}, CT_C1, 11, 0, 1'b0);
    key_reuse = 1'b0;
`endif

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
